// File: rtl/ram_pkg.sv
// Shared types and default widths for the two-port RAM arbiter slice.
package ram_pkg;

   localparam int RAM_ADDR_W = 4;
   localparam int RAM_DATA_W = 4;

   typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;
   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

endpackage

// File: rtl/ram_design.sv
// Single-port synchronous RAM, registered read port, no reset on the array.
module ram_design #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (write_enable) r_mem[address] <= data_in;
      data_out <= r_mem[address];
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, priority flips to
// the other side after every accepted grant.
module rr_arb2
   import ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   owner_t r_prio;

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = (r_prio == OWN_A) ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_prio <= OWN_A;
      else if (advance) r_prio <= gnt[0] ? OWN_B : OWN_A;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester front end for a single-port RAM: zero-fill after reset, then one
// round-robin grant per cycle; read data returns to its owner two cycles after accept.
module ram_arbiter
   import ram_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic              a_req_we,
   input  logic [ADDR_W-1:0] a_req_addr,
   input  logic [DATA_W-1:0] a_req_wdata,
   output logic              a_rsp_valid,
   output logic [DATA_W-1:0] a_rsp_rdata,
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic              b_req_we,
   input  logic [ADDR_W-1:0] b_req_addr,
   input  logic [DATA_W-1:0] b_req_wdata,
   output logic              b_rsp_valid,
   output logic [DATA_W-1:0] b_rsp_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              init_done
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_init_cnt;
   logic              r_init_last;
   logic              r_init_done;
   logic              r_ram_we;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_cmd_rd;
   owner_t            r_cmd_owner;
   logic              r_rsp_pend;
   owner_t            r_rsp_owner;

   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic              w_acc;
   owner_t            w_win;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   // Requests are invisible to the arbiter until the zero-fill has finished.
   assign w_req = {b_req_valid, a_req_valid} & {2{r_state == ST_RUN}};

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (w_req),
      .advance (w_acc),
      .gnt     (w_gnt)
   );

   assign a_req_ready = w_gnt[0];
   assign b_req_ready = w_gnt[1];
   assign w_acc       = |w_gnt;
   assign w_win       = w_gnt[1] ? OWN_B : OWN_A;
   assign w_sel_we    = (w_win == OWN_B) ? b_req_we    : a_req_we;
   assign w_sel_addr  = (w_win == OWN_B) ? b_req_addr  : a_req_addr;
   assign w_sel_wdata = (w_win == OWN_B) ? b_req_wdata : a_req_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_init_cnt  <= '0;
         r_init_last <= 1'b0;
         r_init_done <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_cmd_rd    <= 1'b0;
         r_cmd_owner <= OWN_A;
         r_rsp_pend  <= 1'b0;
         r_rsp_owner <= OWN_A;
      end else begin
         r_rsp_pend  <= r_cmd_rd;
         r_rsp_owner <= r_cmd_owner;
         case (r_state)
            ST_INIT: begin
               r_cmd_rd <= 1'b0;
               // r_init_last marks that the all-ones address write is already on the RAM ports.
               if (r_init_last) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
                  r_ram_we    <= 1'b0;
               end else begin
                  r_ram_we    <= 1'b1;
                  r_ram_addr  <= r_init_cnt;
                  r_ram_wdata <= '0;
                  r_init_last <= (r_init_cnt == '1);
                  r_init_cnt  <= r_init_cnt + ADDR_W'(1);
               end
            end
            ST_RUN: begin
               if (w_acc) begin
                  r_ram_we    <= w_sel_we;
                  r_ram_addr  <= w_sel_addr;
                  r_ram_wdata <= w_sel_wdata;
                  r_cmd_rd    <= !w_sel_we;
                  r_cmd_owner <= w_win;
               end else begin
                  r_ram_we <= 1'b0;
                  r_cmd_rd <= 1'b0;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign ram_we      = r_ram_we;
   assign ram_addr    = r_ram_addr;
   assign ram_wdata   = r_ram_wdata;
   assign init_done   = r_init_done;
   assign a_rsp_valid = r_rsp_pend && (r_rsp_owner == OWN_A);
   assign b_rsp_valid = r_rsp_pend && (r_rsp_owner == OWN_B);
   assign a_rsp_rdata = ram_rdata;
   assign b_rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter + ram_design: init sweep, directed vector table, random traffic
// against a memory/queue reference model, and reset during operation and during init.
module tb_ram_arbiter;

   localparam int AW = 4;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_req_valid = 1'b0, a_req_we = 1'b0;
   logic [AW-1:0] a_req_addr = '0;
   logic [DW-1:0] a_req_wdata = '0;
   logic          b_req_valid = 1'b0, b_req_we = 1'b0;
   logic [AW-1:0] b_req_addr = '0;
   logic [DW-1:0] b_req_wdata = '0;
   logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
   logic [DW-1:0] a_rsp_rdata, b_rsp_rdata;
   logic          ram_we, init_done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
      .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
      .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .init_done(init_done)
   );

   ram_design #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
      .clk(clk), .write_enable(ram_we), .address(ram_addr),
      .data_in(ram_wdata), .data_out(ram_rdata)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: array contents, priority side, and reads awaiting return.
   typedef struct { int due; int own; logic [DW-1:0] data; } rsp_t;
   logic [DW-1:0] mdl_mem [2**AW];
   int            mdl_prio;
   rsp_t          mdl_q [$];

   typedef struct {
      logic av, awe; logic [AW-1:0] aad; logic [DW-1:0] awd;
      logic bv, bwe; logic [AW-1:0] bad; logic [DW-1:0] bwd;
      logic ear, ebr, eav, ebv; logic [DW-1:0] ed;
   } vec_t;
   vec_t tbl [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic next_edge();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // Called at the negedge: compare ready/response against the model, then retire the grant.
   task automatic model_check();
      int   g;
      logic ea, eb;
      logic [DW-1:0] ed;
      rsp_t r;
      g = -1;
      if (a_req_valid && b_req_valid) g = mdl_prio;
      else if (a_req_valid)           g = 0;
      else if (b_req_valid)           g = 1;
      chk("a_req_ready", a_req_ready, g == 0);
      chk("b_req_ready", b_req_ready, g == 1);
      ea = 1'b0; eb = 1'b0; ed = '0;
      while (mdl_q.size() > 0 && mdl_q[0].due <= cyc) begin
         r = mdl_q.pop_front();
         if (r.due == cyc) begin
            if (r.own == 0) ea = 1'b1; else eb = 1'b1;
            ed = r.data;
         end
      end
      chk("a_rsp_valid", a_rsp_valid, ea);
      chk("b_rsp_valid", b_rsp_valid, eb);
      if (ea) chk("a_rsp_rdata", a_rsp_rdata, ed);
      if (eb) chk("b_rsp_rdata", b_rsp_rdata, ed);
      if (g == 0) begin
         if (a_req_we) mdl_mem[a_req_addr] = a_req_wdata;
         else          mdl_q.push_back('{cyc + 2, 0, mdl_mem[a_req_addr]});
      end else if (g == 1) begin
         if (b_req_we) mdl_mem[b_req_addr] = b_req_wdata;
         else          mdl_q.push_back('{cyc + 2, 1, mdl_mem[b_req_addr]});
      end
      if (g >= 0) mdl_prio = 1 - g;
   endtask

   task automatic tick();
      @(negedge clk);
      model_check();
      next_edge();
   endtask

   task automatic drive(input logic av, input logic awe, input int aad, input int awd,
                        input logic bv, input logic bwe, input int bad, input int bwd);
      a_req_valid = av; a_req_we = awe; a_req_addr = AW'(aad); a_req_wdata = DW'(awd);
      b_req_valid = bv; b_req_we = bwe; b_req_addr = AW'(bad); b_req_wdata = DW'(bwd);
   endtask

   // Holds reset two cycles, releases it, and checks the full zero-fill sweep.
   task automatic reset_and_init();
      rst_n = 1'b0;
      mdl_q.delete();
      mdl_prio = 0;
      for (int i = 0; i < 2**AW; i++) mdl_mem[i] = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst ram_we", ram_we, 0);
         chk("rst ram_addr", ram_addr, 0);
         chk("rst ram_wdata", ram_wdata, 0);
         chk("rst a_rsp_valid", a_rsp_valid, 0);
         chk("rst b_rsp_valid", b_rsp_valid, 0);
         chk("rst init_done", init_done, 0);
         chk("rst a_req_ready", a_req_ready, 0);
         chk("rst b_req_ready", b_req_ready, 0);
         next_edge();
      end
      rst_n = 1'b1;
      next_edge();
      for (int i = 0; i < 2**AW; i++) begin
         @(negedge clk);
         chk("init ram_we", ram_we, 1);
         chk("init ram_addr", ram_addr, i);
         chk("init ram_wdata", ram_wdata, 0);
         chk("init init_done", init_done, 0);
         chk("init a_req_ready", a_req_ready, 0);
         chk("init b_req_ready", b_req_ready, 0);
         next_edge();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("post-init ram_we", ram_we, 0);
      chk("post-init init_done", init_done, 1);
      next_edge();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "time limit");
   end

   initial begin
      //            av awe aad awd  bv bwe bad bwd  ear ebr eav ebv ed
      tbl[0]  = '{1, 0, 7, 0,     0, 0, 0, 0,    1, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0,     0, 0, 0, 0,    0, 0, 0, 0, 0};
      tbl[2]  = '{1, 1, 3, 9,     0, 0, 0, 0,    1, 0, 1, 0, 0};
      tbl[3]  = '{1, 0, 3, 0,     0, 0, 0, 0,    1, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 0, 0,     0, 0, 0, 0,    0, 0, 0, 0, 0};
      tbl[5]  = '{0, 0, 0, 0,     0, 0, 0, 0,    0, 0, 1, 0, 9};
      tbl[6]  = '{0, 0, 0, 0,     1, 1, 1, 5,    0, 1, 0, 0, 0};
      tbl[7]  = '{0, 0, 0, 0,     1, 1, 2, 6,    0, 1, 0, 0, 0};
      tbl[8]  = '{1, 0, 1, 0,     1, 0, 2, 0,    1, 0, 0, 0, 0};
      tbl[9]  = '{1, 0, 2, 0,     1, 0, 2, 0,    0, 1, 0, 0, 0};
      tbl[10] = '{1, 0, 2, 0,     1, 0, 1, 0,    1, 0, 1, 0, 5};
      tbl[11] = '{1, 0, 3, 0,     1, 0, 1, 0,    0, 1, 0, 1, 6};
      tbl[12] = '{0, 0, 0, 0,     0, 0, 0, 0,    0, 0, 1, 0, 6};
      tbl[13] = '{0, 0, 0, 0,     0, 0, 0, 0,    0, 0, 0, 1, 5};
      tbl[14] = '{1, 1, 10, 15,   1, 0, 10, 0,   1, 0, 0, 0, 0};
      tbl[15] = '{0, 0, 0, 0,     1, 0, 10, 0,   0, 1, 0, 0, 0};
      tbl[16] = '{0, 0, 0, 0,     0, 0, 0, 0,    0, 0, 0, 0, 0};
      tbl[17] = '{0, 0, 0, 0,     0, 0, 0, 0,    0, 0, 0, 1, 15};

      // Requests held high through reset and init must never be accepted.
      drive(1, 0, 5, 0, 1, 0, 6, 0);
      reset_and_init();

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].av, tbl[i].awe, int'(tbl[i].aad), int'(tbl[i].awd),
               tbl[i].bv, tbl[i].bwe, int'(tbl[i].bad), int'(tbl[i].bwd));
         @(negedge clk);
         chk($sformatf("row%0d a_req_ready", i), a_req_ready, tbl[i].ear);
         chk($sformatf("row%0d b_req_ready", i), b_req_ready, tbl[i].ebr);
         chk($sformatf("row%0d a_rsp_valid", i), a_rsp_valid, tbl[i].eav);
         chk($sformatf("row%0d b_rsp_valid", i), b_rsp_valid, tbl[i].ebv);
         if (tbl[i].eav) chk($sformatf("row%0d a_rsp_rdata", i), a_rsp_rdata, tbl[i].ed);
         if (tbl[i].ebv) chk($sformatf("row%0d b_rsp_rdata", i), b_rsp_rdata, tbl[i].ed);
         model_check();
         next_edge();
      end

      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();

      // Read accepted, then reset in the following cycle: the response must never appear.
      drive(1, 0, 10, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 4, 0, 1, 0, 5, 0);
      reset_and_init();
      drive(1, 0, 10, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();

      // Reset in the middle of the zero-fill sweep; it must restart from address 0.
      rst_n = 1'b0;
      next_edge();
      rst_n = 1'b1;
      repeat (6) next_edge();
      reset_and_init();
      for (int n = 0; n < 40; n++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
